// File: rtl/display_pkg.sv
// Shared display definitions: default VGA timing, colour and position types,
// and a small helper for sync window decoding.
package display_pkg;

    localparam int RESOLUTION_X_DEF = 400;
    localparam int RESOLUTION_Y_DEF = 300;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 56;
    localparam int H_SYNC_DEF    = 120;
    localparam int H_BACK_DEF    = 64;

    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 37;
    localparam int V_SYNC_DEF    = 6;
    localparam int V_BACK_DEF    = 23;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Framebuffer coordinate at the default geometry.
    typedef struct packed {
        logic [$clog2(RESOLUTION_X_DEF)-1:0] x;
        logic [$clog2(RESOLUTION_Y_DEF)-1:0] y;
    } pixel_pos_t;

    // Raster-side control bits that travel down the delay line with each pixel.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
        logic vblank;
    } scan_ctrl_t;

    // True when pos lies in [start, start+len).
    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counters plus the undelayed sync/active/frame-start decode.
module video_timing
    import display_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter bit SYNC_POL  = 1'b1,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          h_wrap_o,
    output logic          active0_o,
    output logic          hsync0_o,
    output logic          vsync0_o,
    output logic          vblank0_o,
    output logic          frame_start0_o
);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_wrap;
    logic          v_wrap;

    assign h_wrap = (int'(h_cnt_q) == H_TOTAL - 1);
    assign v_wrap = (int'(v_cnt_q) == V_TOTAL - 1);

    // Next raster position: h wraps every line, v steps on each h wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            h_cnt_d = '0;
            v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
        end
    end

    // Raster position registers; reset parks the raster at (0,0).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o        = h_cnt_q;
    assign v_cnt_o        = v_cnt_q;
    assign h_wrap_o       = h_wrap;
    assign active0_o      = (int'(h_cnt_q) < H_VISIBLE) && (int'(v_cnt_q) < V_VISIBLE);
    assign hsync0_o       = in_window(int'(h_cnt_q), H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vsync0_o       = in_window(int'(v_cnt_q), V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vblank0_o      = (int'(v_cnt_q) >= V_VISIBLE);
    assign frame_start0_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: upscaled read addressing, framebuffer -> palette
// lookup, and a 3-stage control delay so colour and sync reach the pins together.
module framebuffer_scanout
    import display_pkg::*;
#(
    parameter int RESOLUTION_X   = RESOLUTION_X_DEF,
    parameter int RESOLUTION_Y   = RESOLUTION_Y_DEF,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int SCALE          = 2,
    parameter int H_VISIBLE      = H_VISIBLE_DEF,
    parameter int H_FRONT        = H_FRONT_DEF,
    parameter int H_SYNC         = H_SYNC_DEF,
    parameter int H_BACK         = H_BACK_DEF,
    parameter int V_VISIBLE      = V_VISIBLE_DEF,
    parameter int V_FRONT        = V_FRONT_DEF,
    parameter int V_SYNC         = V_SYNC_DEF,
    parameter int V_BACK         = V_BACK_DEF,
    parameter bit SYNC_POL       = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [$clog2(RESOLUTION_X)-1:0]   fb_rd_x,
    output logic [$clog2(RESOLUTION_Y)-1:0]   fb_rd_y,
    output logic                              fb_rd_en,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] fb_rd_index,
    output logic [$clog2(PALETTE_LENGTH)-1:0] palette_rd_index,
    input  logic [COLOR_BITS-1:0]             palette_rd_color,
    output logic [3:0]                        vga_r,
    output logic [3:0]                        vga_g,
    output logic [3:0]                        vga_b,
    output logic                              vga_hsync,
    output logic                              vga_vsync,
    output logic                              frame_start,
    output logic                              vblank
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(RESOLUTION_X);
    localparam int YW      = $clog2(RESOLUTION_Y);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam scan_ctrl_t CTRL_IDLE = '{active: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                                         frame_start: 1'b0, vblank: 1'b0};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    scan_ctrl_t    ctrl_p0;

    logic [SW-1:0] x_sub_q, x_sub_d;
    logic [SW-1:0] y_sub_q, y_sub_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    scan_ctrl_t    ctrl_p1_q, ctrl_p2_q, ctrl_p3_q;
    rgb_t          rgb_p3_q;

    video_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .SYNC_POL  (SYNC_POL)
    ) u_timing (
        .clk_i          (clk),
        .rst_ni         (reset),
        .h_cnt_o        (h_cnt),
        .v_cnt_o        (v_cnt),
        .h_wrap_o       (h_wrap),
        .active0_o      (ctrl_p0.active),
        .hsync0_o       (ctrl_p0.hsync),
        .vsync0_o       (ctrl_p0.vsync),
        .vblank0_o      (ctrl_p0.vblank),
        .frame_start0_o (ctrl_p0.frame_start)
    );

    // Divider-free scaling: sub-counters step the framebuffer address once
    // every SCALE pixels/lines and hold it through blanking.
    always_comb begin
        x_sub_d = x_sub_q;
        x_d     = x_q;
        y_sub_d = y_sub_q;
        y_d     = y_q;
        if (h_wrap) begin
            x_sub_d = '0;
            x_d     = '0;
            if (int'(v_cnt) == V_TOTAL - 1) begin
                y_sub_d = '0;
                y_d     = '0;
            end else if (int'(v_cnt) < V_VISIBLE - 1) begin
                if (y_sub_q == SW'(SCALE - 1)) begin
                    y_sub_d = '0;
                    y_d     = y_q + YW'(1);
                end else begin
                    y_sub_d = y_sub_q + SW'(1);
                end
            end
        end else if (int'(h_cnt) < H_VISIBLE - 1) begin
            if (x_sub_q == SW'(SCALE - 1)) begin
                x_sub_d = '0;
                x_d     = x_q + XW'(1);
            end else begin
                x_sub_d = x_sub_q + SW'(1);
            end
        end
    end

    // Scaling counter registers, kept in lockstep with the raster counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_sub_q <= '0;
            x_q     <= '0;
            y_sub_q <= '0;
            y_q     <= '0;
        end else begin
            x_sub_q <= x_sub_d;
            x_q     <= x_d;
            y_sub_q <= y_sub_d;
            y_q     <= y_d;
        end
    end

    // Stage 0: address out. The strobe is gated by reset so nothing is read
    // while the raster is parked at (0,0).
    assign fb_rd_x  = x_q;
    assign fb_rd_y  = y_q;
    assign fb_rd_en = ctrl_p0.active & reset;

    // Stage 1: framebuffer data goes straight on to the palette address.
    assign palette_rd_index = fb_rd_index;

    // Control delay line matching the two RAM read latencies.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_p1_q <= CTRL_IDLE;
            ctrl_p2_q <= CTRL_IDLE;
        end else begin
            ctrl_p1_q <= ctrl_p0;
            ctrl_p2_q <= ctrl_p1_q;
        end
    end

    // Stage 3: register colour onto the pins, blanked outside the visible area.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_p3_q <= CTRL_IDLE;
            rgb_p3_q  <= '0;
        end else begin
            ctrl_p3_q <= ctrl_p2_q;
            rgb_p3_q  <= ctrl_p2_q.active ? rgb_t'(palette_rd_color[11:0]) : '0;
        end
    end

    assign vga_r       = rgb_p3_q.r;
    assign vga_g       = rgb_p3_q.g;
    assign vga_b       = rgb_p3_q.b;
    assign vga_hsync   = ctrl_p3_q.hsync;
    assign vga_vsync   = ctrl_p3_q.vsync;
    assign frame_start = ctrl_p3_q.frame_start;
    assign vblank      = ctrl_p3_q.vblank;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout at a reduced raster (24 x 18 clocks, 8 x 6
// framebuffer, SCALE 2) so whole frames fit in a short run.
module tb_framebuffer_scanout;

    localparam int RX = 8;
    localparam int RY = 6;
    localparam int SC = 2;
    localparam int HV = 16;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 3;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 24
    localparam int VT = VV + VF + VS + VB;   // 18

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  fb_rd_x;
    logic [2:0]  fb_rd_y;
    logic        fb_rd_en;
    logic [7:0]  fb_rd_index;
    logic [7:0]  palette_rd_index;
    logic [11:0] palette_rd_color;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hsync, vga_vsync, frame_start, vblank;
    logic        pal_fff = 1'b0;

    int checks = 0;
    int failures = 0;
    int t = 0;   // clocks since the raster left reset at (0,0)

    framebuffer_scanout #(
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(256), .COLOR_BITS(12),
        .SCALE(SC),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .fb_rd_x(fb_rd_x), .fb_rd_y(fb_rd_y), .fb_rd_en(fb_rd_en),
        .fb_rd_index(fb_rd_index),
        .palette_rd_index(palette_rd_index), .palette_rd_color(palette_rd_color),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_start(frame_start), .vblank(vblank)
    );

    always #5 clk = ~clk;

    // RAM models: fb[x][y] = x, palette[i] = {i[3:0], 5, A} (or all-ones on demand).
    always @(posedge clk) begin
        fb_rd_index      <= {5'd0, fb_rd_x};
        palette_rd_color <= pal_fff ? 12'hFFF : {palette_rd_index[3:0], 4'h5, 4'hA};
    end

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    // Raster position at the pins lags the counters by 3 clocks.
    function automatic int ph(input int tt);
        return (tt - 3) % HT;
    endfunction
    function automatic int pv(input int tt);
        return ((tt - 3) / HT) % VT;
    endfunction

    function automatic logic [11:0] exp_rgb(input int tt, input logic fff);
        int h, v;
        if (tt < 3) return 12'h000;
        h = ph(tt);
        v = pv(tt);
        if (h < HV && v < VV) return fff ? 12'hFFF : {4'(h / SC), 4'h5, 4'hA};
        return 12'h000;
    endfunction

    function automatic int exp_x(input int tt);
        int h;
        h = tt % HT;
        return (h < HV) ? h / SC : RX - 1;
    endfunction

    function automatic int exp_y(input int tt);
        int v;
        v = (tt / HT) % VT;
        return (v < VV) ? v / SC : RY - 1;
    endfunction

    function automatic logic exp_en(input int tt);
        return ((tt % HT) < HV) && (((tt / HT) % VT) < VV);
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL reset_rgb: got %h expected 000", {vga_r, vga_g, vga_b}); end
        checks++; if (vga_hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync: got %b expected 0", vga_hsync); end
        checks++; if (vga_vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync: got %b expected 0", vga_vsync); end
        checks++; if (fb_rd_en !== 1'b0) begin failures++; $display("FAIL reset_fb_rd_en: got %b expected 0", fb_rd_en); end
        checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        checks++; if (vblank !== 1'b0) begin failures++; $display("FAIL reset_vblank: got %b expected 0", vblank); end
        reset = 1'b1;
        #1;
        t = 0;
        checks++; if (fb_rd_x !== 3'd0) begin failures++; $display("FAIL release_x: got %0d expected 0", fb_rd_x); end
        checks++; if (fb_rd_y !== 3'd0) begin failures++; $display("FAIL release_y: got %0d expected 0", fb_rd_y); end
        checks++; if (fb_rd_en !== 1'b1) begin failures++; $display("FAIL release_en: got %b expected 1", fb_rd_en); end
    endtask

    task automatic test_pixel_pipeline();
        for (int i = 0; i < 2 * HT; i++) begin
            tick();
            checks++; if (int'(fb_rd_x) !== exp_x(t)) begin failures++; $display("FAIL pix_x t=%0d: got %0d expected %0d", t, fb_rd_x, exp_x(t)); end
            checks++; if (fb_rd_en !== exp_en(t)) begin failures++; $display("FAIL pix_en t=%0d: got %b expected %b", t, fb_rd_en, exp_en(t)); end
            checks++; if ({vga_r, vga_g, vga_b} !== exp_rgb(t, 1'b0)) begin failures++; $display("FAIL pix_rgb t=%0d: got %h expected %h", t, {vga_r, vga_g, vga_b}, exp_rgb(t, 1'b0)); end
        end
    endtask

    task automatic test_line_timing();
        int guard;
        int hs_count;
        int hs_first;
        pal_fff = 1'b1;
        tick();
        tick();
        guard = 0;
        while (ph(t) != 0 && guard < 2 * HT) begin tick(); guard++; end
        hs_count = 0;
        hs_first = -1;
        for (int i = 0; i < HT; i++) begin
            checks++; if ({vga_r, vga_g, vga_b} !== exp_rgb(t, 1'b1)) begin failures++; $display("FAIL line_rgb h=%0d: got %h expected %h", ph(t), {vga_r, vga_g, vga_b}, exp_rgb(t, 1'b1)); end
            checks++; if (vga_hsync !== (ph(t) >= HV + HF && ph(t) < HV + HF + HS)) begin failures++; $display("FAIL line_hsync h=%0d: got %b", ph(t), vga_hsync); end
            if (vga_hsync === 1'b1) begin
                if (hs_first < 0) hs_first = ph(t);
                hs_count++;
            end
            tick();
        end
        checks++; if (hs_count !== HS) begin failures++; $display("FAIL hsync_width: got %0d expected %0d", hs_count, HS); end
        checks++; if (hs_first !== HV + HF) begin failures++; $display("FAIL hsync_start: got %0d expected %0d", hs_first, HV + HF); end
        pal_fff = 1'b0;
    endtask

    task automatic test_vertical_scaling();
        int max_y;
        int en_blank;
        max_y = 0;
        en_blank = 0;
        for (int i = 0; i < HT * VT; i++) begin
            tick();
            checks++; if (int'(fb_rd_y) !== exp_y(t)) begin failures++; $display("FAIL vs_y t=%0d: got %0d expected %0d", t, fb_rd_y, exp_y(t)); end
            checks++; if (fb_rd_en !== exp_en(t)) begin failures++; $display("FAIL vs_en t=%0d: got %b expected %b", t, fb_rd_en, exp_en(t)); end
            if (int'(fb_rd_y) > max_y) max_y = int'(fb_rd_y);
            if (((t / HT) % VT) >= VV && fb_rd_en === 1'b1) en_blank++;
        end
        checks++; if (max_y !== RY - 1) begin failures++; $display("FAIL max_y: got %0d expected %0d", max_y, RY - 1); end
        checks++; if (en_blank !== 0) begin failures++; $display("FAIL en_in_vblank: got %0d expected 0", en_blank); end
    endtask

    task automatic test_frame();
        int guard;
        int t0;
        int t1;
        int vs_count;
        int vs_first;
        logic done;
        guard = 0;
        while (frame_start !== 1'b1 && guard < 2 * HT * VT) begin tick(); guard++; end
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL frame_start_seen: got %b expected 1", frame_start); end
        t0 = t;
        t1 = -1;
        vs_count = 0;
        vs_first = -1;
        done = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !done; i++) begin
            tick();
            checks++; if (vga_vsync !== (pv(t) >= VV + VF && pv(t) < VV + VF + VS)) begin failures++; $display("FAIL frame_vsync v=%0d: got %b", pv(t), vga_vsync); end
            checks++; if (vblank !== (pv(t) >= VV)) begin failures++; $display("FAIL frame_vblank v=%0d: got %b", pv(t), vblank); end
            checks++; if (frame_start !== (ph(t) == 0 && pv(t) == 0)) begin failures++; $display("FAIL frame_pulse t=%0d: got %b", t, frame_start); end
            if (vga_vsync === 1'b1) begin
                if (vs_first < 0) vs_first = pv(t);
                vs_count++;
            end
            if (frame_start === 1'b1) begin
                t1 = t;
                done = 1'b1;
            end
        end
        checks++; if (t1 - t0 !== HT * VT) begin failures++; $display("FAIL frame_period: got %0d expected %0d", t1 - t0, HT * VT); end
        checks++; if (vs_count !== VS * HT) begin failures++; $display("FAIL vsync_width: got %0d expected %0d", vs_count, VS * HT); end
        checks++; if (vs_first !== VV + VF) begin failures++; $display("FAIL vsync_start: got %0d expected %0d", vs_first, VV + VF); end
    endtask

    task automatic test_midframe_reset();
        int guard;
        guard = 0;
        while (!((t % HT) == 8 && ((t / HT) % VT) == 5) && guard < 2 * HT * VT) begin tick(); guard++; end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h25A) begin failures++; $display("FAIL mid_pre_rgb: got %h expected 25A", {vga_r, vga_g, vga_b}); end
        reset = 1'b0;
        #1;
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin failures++; $display("FAIL mid_async_rgb: got %h expected 000", {vga_r, vga_g, vga_b}); end
        checks++; if (fb_rd_x !== 3'd0 || fb_rd_y !== 3'd0) begin failures++; $display("FAIL mid_async_xy: got %0d,%0d expected 0,0", fb_rd_x, fb_rd_y); end
        checks++; if (fb_rd_en !== 1'b0) begin failures++; $display("FAIL mid_async_en: got %b expected 0", fb_rd_en); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        t = 0;
        checks++; if (fb_rd_x !== 3'd0 || fb_rd_y !== 3'd0 || fb_rd_en !== 1'b1) begin failures++; $display("FAIL mid_restart: got x=%0d y=%0d en=%b expected 0 0 1", fb_rd_x, fb_rd_y, fb_rd_en); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL mid_fs_early t=%0d: got %b expected 0", t, frame_start); end
            tick();
        end
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL mid_fs_at3: got %b expected 1", frame_start); end
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h05A) begin failures++; $display("FAIL mid_first_pixel: got %h expected 05A", {vga_r, vga_g, vga_b}); end
        tick();
        tick();
        checks++; if ({vga_r, vga_g, vga_b} !== 12'h15A) begin failures++; $display("FAIL mid_third_pixel: got %h expected 15A", {vga_r, vga_g, vga_b}); end
    endtask

    initial begin
        test_reset();
        test_pixel_pipeline();
        test_line_timing();
        test_vertical_scaling();
        test_frame();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
